// File: rtl/spi_adc_responder_pkg.sv
// Shared constants and FSM encoding for the SPI ADC responder.
package spi_adc_responder_pkg;

  // Frame length: width of the command word and the returned sample
  localparam int SPI_BITS   = 16;

  // Field positions inside the command word
  localparam int CMD_CH_LSB = 7;
  localparam int CMD_EN_BIT = 11;

  // Responder FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } spi_state_e;

endpackage

// File: rtl/spi_adc_responder_pin_sync.sv
// Synchronizer for one asynchronous SPI pin, with rise/fall pulses.
// Edge pulses are held off until the pipeline has filled after reset.
// A pin that is already away from its reset value at reset release then
// settles quietly instead of producing a false edge.
module spi_pin_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;
  logic [STAGES:0]   r_fill;
  logic              w_armed;

  // Synchronizer chain, previous-value register and post-reset fill tracker
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= {STAGES{RST_VAL}};
      r_prev <= RST_VAL;
      r_fill <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_pin};
      r_prev <= r_sync[STAGES-1];
      r_fill <= {r_fill[STAGES-1:0], 1'b1};
    end
  end

  assign w_armed = r_fill[STAGES];
  assign o_level = r_sync[STAGES-1];
  assign o_rise  = w_armed &  r_sync[STAGES-1] & ~r_prev;
  assign o_fall  = w_armed & ~r_sync[STAGES-1] &  r_prev;

endmodule

// File: rtl/spi_adc_responder.sv
// SPI mode-0 slave standing in for an external ADC: takes a command word on
// MOSI and returns SAMPLE_DATA on MISO, MSB first. All SPI pins are
// oversampled in the SYS_CLK domain.
module spi_adc_responder
  import spi_adc_responder_pkg::*;
#(
  parameter int BITS        = SPI_BITS,
  parameter int SYNC_STAGES = 2,
  parameter int CH_LSB      = CMD_CH_LSB
) (
  input  logic            SYS_CLK,
  input  logic            RSTbar,
  input  logic            SCK,
  input  logic            CSbar,
  input  logic            MOSI,
  input  logic [BITS-1:0] SAMPLE_DATA,
  output logic            MISO,
  output logic            MISO_OE,
  output logic [BITS-1:0] CMD,
  output logic [1:0]      CH,
  output logic            CMD_VALID,
  output logic            FRAME_ERR,
  output logic [15:0]     FRAME_CNT,
  output logic            BUSY,
  output spi_state_e      o_state
);

  localparam int              CW       = $clog2(BITS + 1);
  localparam logic [CW-1:0]   LAST_BIT = CW'(BITS - 1);

  // Synchronized pin levels and edge pulses
  logic w_sck_level, w_sck_rise, w_sck_fall;
  logic w_cs_level,  w_cs_rise,  w_cs_fall;
  logic w_mosi,      w_mosi_rise, w_mosi_fall;
  logic w_unused;

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .i_clk   (SYS_CLK),
    .i_rst_n (RSTbar),
    .i_pin   (SCK),
    .o_level (w_sck_level),
    .o_rise  (w_sck_rise),
    .o_fall  (w_sck_fall)
  );

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .i_clk   (SYS_CLK),
    .i_rst_n (RSTbar),
    .i_pin   (CSbar),
    .o_level (w_cs_level),
    .o_rise  (w_cs_rise),
    .o_fall  (w_cs_fall)
  );

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .i_clk   (SYS_CLK),
    .i_rst_n (RSTbar),
    .i_pin   (MOSI),
    .o_level (w_mosi),
    .o_rise  (w_mosi_rise),
    .o_fall  (w_mosi_fall)
  );

  // Levels/edges that the responder has no use for
  assign w_unused = &{1'b0, w_sck_level, w_cs_level, w_mosi_rise, w_mosi_fall};

  // State and datapath registers
  spi_state_e        r_state;
  spi_state_e        w_state_next;
  logic [BITS-1:0]   r_tx;
  logic [BITS-2:0]   r_rx;
  logic [CW-1:0]     r_bit_cnt;
  logic [BITS-1:0]   r_cmd;
  logic [1:0]        r_ch;
  logic              r_cmd_valid;
  logic              r_frame_err;
  logic [15:0]       r_frame_cnt;

  // FSM control strobes
  logic              w_load;
  logic              w_rx_shift;
  logic              w_tx_shift;
  logic              w_complete;
  logic              w_err;
  logic [BITS-1:0]   w_rx_next;

  assign w_rx_next = {r_rx, w_mosi};

  // FSM state register
  always_ff @(posedge SYS_CLK or negedge RSTbar) begin
    if (!RSTbar) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and control strobes; a completing rise wins over a
  // simultaneous CSbar rise, and SCK edges outside SHIFT are dropped
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_rx_shift   = 1'b0;
    w_tx_shift   = 1'b0;
    w_complete   = 1'b0;
    w_err        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cs_fall) begin
          w_load       = 1'b1;
          w_state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        w_rx_shift = w_sck_rise;
        w_tx_shift = w_sck_fall;
        if (w_sck_rise && (r_bit_cnt == LAST_BIT)) begin
          w_complete   = 1'b1;
          w_state_next = w_cs_rise ? ST_IDLE : ST_DONE;
        end else if (w_cs_rise) begin
          w_err        = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      ST_DONE: begin
        if (w_cs_rise) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Shift registers and bit counter
  always_ff @(posedge SYS_CLK or negedge RSTbar) begin
    if (!RSTbar) begin
      r_tx      <= '0;
      r_rx      <= '0;
      r_bit_cnt <= '0;
    end else if (w_load) begin
      r_tx      <= SAMPLE_DATA;
      r_rx      <= '0;
      r_bit_cnt <= '0;
    end else begin
      if (w_tx_shift) begin
        r_tx <= {r_tx[BITS-2:0], 1'b0};
      end
      if (w_rx_shift) begin
        r_rx      <= w_rx_next[BITS-2:0];
        r_bit_cnt <= r_bit_cnt + CW'(1);
      end
    end
  end

  // Command capture, status pulses and frame counter
  always_ff @(posedge SYS_CLK or negedge RSTbar) begin
    if (!RSTbar) begin
      r_cmd       <= '0;
      r_ch        <= '0;
      r_cmd_valid <= 1'b0;
      r_frame_err <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_cmd_valid <= w_complete;
      r_frame_err <= w_err;
      if (w_complete) begin
        r_cmd       <= w_rx_next;
        r_ch        <= w_rx_next[CH_LSB+1:CH_LSB];
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

  // MISO only carries data while shifting; DONE and IDLE drive 0
  assign MISO      = (r_state == ST_SHIFT) & r_tx[BITS-1];
  assign MISO_OE   = (r_state != ST_IDLE);
  assign BUSY      = (r_state == ST_SHIFT);
  assign CMD       = r_cmd;
  assign CH        = r_ch;
  assign CMD_VALID = r_cmd_valid;
  assign FRAME_ERR = r_frame_err;
  assign FRAME_CNT = r_frame_cnt;
  assign o_state   = r_state;

endmodule

// File: tb/tb_spi_adc_responder.sv
// Directed bench for spi_adc_responder: a mode-0 SPI master driven from
// SYS_CLK (40 MHz) with SCK at 5 MHz (4 SYS_CLK per SCK phase).
`timescale 1ns/1ps
module tb_spi_adc_responder;
  import spi_adc_responder_pkg::*;

  // Clock / reset and DUT signals
  logic        SYS_CLK = 1'b0;
  logic        RSTbar  = 1'b0;
  logic        SCK     = 1'b0;
  logic        CSbar   = 1'b1;
  logic        MOSI    = 1'b0;
  logic [15:0] SAMPLE_DATA = 16'h0000;
  logic        MISO;
  logic        MISO_OE;
  logic [15:0] CMD;
  logic [1:0]  CH;
  logic        CMD_VALID;
  logic        FRAME_ERR;
  logic [15:0] FRAME_CNT;
  logic        BUSY;
  spi_state_e  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int cv_cnt  = 0;
  int fe_cnt  = 0;

  logic [31:0] rx, rx1, rx2, rx3;

  always #12.5 SYS_CLK = ~SYS_CLK;

  spi_adc_responder dut (
    .SYS_CLK     (SYS_CLK),
    .RSTbar      (RSTbar),
    .SCK         (SCK),
    .CSbar       (CSbar),
    .MOSI        (MOSI),
    .SAMPLE_DATA (SAMPLE_DATA),
    .MISO        (MISO),
    .MISO_OE     (MISO_OE),
    .CMD         (CMD),
    .CH          (CH),
    .CMD_VALID   (CMD_VALID),
    .FRAME_ERR   (FRAME_ERR),
    .FRAME_CNT   (FRAME_CNT),
    .BUSY        (BUSY),
    .o_state     (dbg_state)
  );

  // Pulse counters, sampled mid-cycle
  always @(negedge SYS_CLK) begin
    if (CMD_VALID) cv_cnt++;
    if (FRAME_ERR) fe_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge SYS_CLK);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Clock n bits out of word (MSB of the n first); rx collects MISO as the
  // master sees it just before each SCK rise
  task automatic spi_bits(input logic [31:0] word, input int n, output logic [31:0] rx_o);
    rx_o = 32'h0;
    for (int i = n - 1; i >= 0; i--) begin
      MOSI = word[i];
      tick(4);
      rx_o = {rx_o[30:0], MISO};
      SCK = 1'b1;
      tick(4);
      SCK = 1'b0;
    end
  endtask

  task automatic spi_frame(input logic [15:0] sample, input logic [31:0] word,
                           input int n, input int gap, output logic [31:0] rx_o);
    SAMPLE_DATA = sample;
    CSbar = 1'b0;
    tick(4);
    spi_bits(word, n, rx_o);
    tick(4);
    CSbar = 1'b1;
    tick(gap);
  endtask

  initial begin
    // Reset values
    tick(3); #1;
    check("reset.miso",      32'(MISO),      32'h0);
    check("reset.miso_oe",   32'(MISO_OE),   32'h0);
    check("reset.cmd",       32'(CMD),       32'h0);
    check("reset.ch",        32'(CH),        32'h0);
    check("reset.cmd_valid", 32'(CMD_VALID), 32'h0);
    check("reset.frame_err", 32'(FRAME_ERR), 32'h0);
    check("reset.frame_cnt", 32'(FRAME_CNT), 32'h0);
    check("reset.busy",      32'(BUSY),      32'h0);
    check("reset.state",     32'(dbg_state), 32'(ST_IDLE));
    RSTbar = 1'b1;
    tick(6);

    // Nominal frame
    spi_frame(16'hA5C3, 32'h1880, 16, 6, rx);
    tick(2); #1;
    check("nom.rx",        32'(rx[15:0]),  32'hA5C3);
    check("nom.cmd",       32'(CMD),       32'h1880);
    check("nom.ch",        32'(CH),        32'h1);
    check("nom.cv_cnt",    32'(cv_cnt),    32'd1);
    check("nom.frame_cnt", 32'(FRAME_CNT), 32'd1);
    check("nom.fe_cnt",    32'(fe_cnt),    32'd0);
    check("nom.miso_oe",   32'(MISO_OE),   32'h0);

    // Short frame: 9 SCK then CSbar rises
    SAMPLE_DATA = 16'hC000;
    CSbar = 1'b0;
    tick(4); #1;
    check("short.miso_oe_on", 32'(MISO_OE), 32'h1);
    check("short.busy_on",    32'(BUSY),    32'h1);
    check("short.miso_msb",   32'(MISO),    32'h1);
    spi_bits(32'h0155, 9, rx);
    tick(4);
    CSbar = 1'b1;
    tick(4); #1;
    check("short.miso_oe_off", 32'(MISO_OE),   32'h0);
    check("short.rx",          32'(rx[8:0]),   32'h180);
    check("short.fe_cnt",      32'(fe_cnt),    32'd1);
    check("short.cmd",         32'(CMD),       32'h1880);
    check("short.frame_cnt",   32'(FRAME_CNT), 32'd1);
    check("short.cv_cnt",      32'(cv_cnt),    32'd1);
    tick(4);

    // Over-clocked frame: 20 SCK, first 16 bits are the command
    spi_frame(16'hFFFF, 32'h19000, 20, 6, rx);
    tick(2); #1;
    check("over.cmd",       32'(CMD),        32'h1900);
    check("over.ch",        32'(CH),         32'h2);
    check("over.rx16",      32'(rx[19:4]),   32'hFFFF);
    check("over.rx_tail",   32'(rx[3:0]),    32'h0);
    check("over.frame_cnt", 32'(FRAME_CNT),  32'd2);
    check("over.cv_cnt",    32'(cv_cnt),     32'd2);

    // Back-to-back frames with 2 SYS_CLK of CSbar high between them
    spi_frame(16'h0001, 32'h0080, 16, 2, rx1);
    spi_frame(16'h8000, 32'h0100, 16, 2, rx2);
    spi_frame(16'hFFFF, 32'h0180, 16, 2, rx3);
    tick(6); #1;
    check("b2b.rx1",       32'(rx1[15:0]), 32'h0001);
    check("b2b.rx2",       32'(rx2[15:0]), 32'h8000);
    check("b2b.rx3",       32'(rx3[15:0]), 32'hFFFF);
    check("b2b.frame_cnt", 32'(FRAME_CNT), 32'd5);
    check("b2b.cv_cnt",    32'(cv_cnt),    32'd5);
    check("b2b.cmd",       32'(CMD),       32'h0180);
    check("b2b.ch",        32'(CH),        32'h3);
    check("b2b.fe_cnt",    32'(fe_cnt),    32'd1);

    // Reset mid-frame after 7 bits, CSbar held low through reset release
    SAMPLE_DATA = 16'hFFFF;
    CSbar = 1'b0;
    tick(4);
    spi_bits(32'h0030, 7, rx);
    tick(2);
    RSTbar = 1'b0;
    #1;
    check("midrst.miso",      32'(MISO),      32'h0);
    check("midrst.miso_oe",   32'(MISO_OE),   32'h0);
    check("midrst.cmd",       32'(CMD),       32'h0);
    check("midrst.ch",        32'(CH),        32'h0);
    check("midrst.frame_cnt", 32'(FRAME_CNT), 32'h0);
    check("midrst.busy",      32'(BUSY),      32'h0);
    check("midrst.cmd_valid", 32'(CMD_VALID), 32'h0);
    check("midrst.frame_err", 32'(FRAME_ERR), 32'h0);
    tick(3);
    RSTbar = 1'b1;
    tick(8);
    spi_bits(32'h0007, 3, rx);
    tick(4); #1;
    check("cslow.busy",    32'(BUSY),    32'h0);
    check("cslow.miso_oe", 32'(MISO_OE), 32'h0);
    check("cslow.state",   32'(dbg_state), 32'(ST_IDLE));
    check("cslow.cv_cnt",  32'(cv_cnt),  32'd5);
    check("cslow.fe_cnt",  32'(fe_cnt),  32'd1);
    CSbar = 1'b1;
    tick(4);
    spi_frame(16'h5A5A, 32'h1F80, 16, 6, rx);
    tick(2); #1;
    check("postrst.rx",        32'(rx[15:0]),  32'h5A5A);
    check("postrst.cmd",       32'(CMD),       32'h1F80);
    check("postrst.ch",        32'(CH),        32'h3);
    check("postrst.frame_cnt", 32'(FRAME_CNT), 32'd1);
    check("postrst.cv_cnt",    32'(cv_cnt),    32'd6);

    // Frame counter wrap
    force dut.r_frame_cnt = 16'hFFFF;
    tick(1);
    release dut.r_frame_cnt;
    tick(1); #1;
    check("wrap.preset", 32'(FRAME_CNT), 32'hFFFF);
    spi_frame(16'h1234, 32'h0080, 16, 4, rx);
    tick(2); #1;
    check("wrap.frame_cnt", 32'(FRAME_CNT), 32'h0000);
    check("wrap.cv_cnt",    32'(cv_cnt),    32'd7);
    check("wrap.cmd",       32'(CMD),       32'h0080);
    check("wrap.rx",        32'(rx[15:0]),  32'h1234);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
